// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller and the ALU beside it: opcodes,
// instruction field layout and the controller state encoding.
package cpu_pkg;

    // ALU opcodes, shared with the ALU; the same values are the instruction ops
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_INC  = 4'h3;

    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JC   = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int INSTR_W = 12;
    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_OUT_WAIT,
        S_HALT
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_INC;
    endfunction

endpackage

// File: rtl/cpu_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC over a synchronous instruction ROM,
// driving an external combinational ALU and a valid/ready output port.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [11:0]       imem_data,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        acc,
    output logic              carry,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_t              state;
    logic [INSTR_W-1:0]  ir;
    logic [3:0]          ir_op;
    logic [7:0]          ir_imm;
    logic [ADDR_W-1:0]   pc_inc;

    assign ir_op  = ir[OP_MSB:OP_LSB];
    assign ir_imm = ir[IMM_MSB:IMM_LSB];
    assign pc_inc = pc + ADDR_W'(1);

    // The ROM registers its output, so the enable must be high during FETCH
    // itself, not one cycle later.
    assign imem_addr = pc;
    assign imem_en   = (state == S_FETCH);
    assign halted    = (state == S_HALT);
    assign alu_a     = acc;

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_opcode = '0;
        alu_b      = '0;
        if (state == S_EXEC && is_alu_op(ir_op)) begin
            alu_opcode = ir_op;
            alu_b      = ir_imm;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; a later assignment to the same register wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= ADDR_W'(RESET_PC);
            acc       <= '0;
            carry     <= 1'b0;
            ir        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ir    <= imem_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    pc    <= pc_inc;
                    case (ir_op)
                        OP_ADD, OP_SUB, OP_AND, OP_INC: begin
                            acc   <= alu_result;
                            carry <= alu_carry;
                        end
                        OP_LDI: acc <= ir_imm;
                        OP_JMP: pc <= ADDR_W'(ir_imm);
                        OP_JC: begin
                            if (carry) pc <= ADDR_W'(ir_imm);
                        end
                        OP_OUT: begin
                            out_data  <= acc;
                            out_valid <= 1'b1;
                            pc        <= pc;
                            state     <= S_OUT_WAIT;
                        end
                        OP_HALT: begin
                            pc    <= pc;
                            state <= S_HALT;
                        end
                        default: ;
                    endcase
                end
                S_OUT_WAIT: begin
                    // out_valid is always high here, so ready alone completes it
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pc        <= pc_inc;
                        state     <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc    <= ADDR_W'(RESET_PC);
                        acc   <= '0;
                        carry <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with a behavioural ROM and ALU; output-port
// transfers are checked against a queue of expected bytes.
module tb_cpu_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  imem_addr;
    logic        imem_en;
    logic [11:0] imem_data;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_carry;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  acc;
    logic        carry;
    logic [7:0]  pc;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [11:0] rom [256];
    logic [7:0]  sb_q [$];

    always #5 clk = ~clk;

    cpu_ctrl #(.ADDR_W(8), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .carry(carry), .pc(pc), .halted(halted)
    );

    always @(posedge clk) begin
        if (imem_en) imem_data <= rom[imem_addr];
    end

    // Reference ALU; for SUB carry means no borrow
    always_comb begin
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        case (alu_opcode)
            OP_ADD: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: begin
                alu_result = alu_a - alu_b;
                alu_carry  = (alu_a >= alu_b);
            end
            OP_AND: alu_result = alu_a & alu_b;
            OP_INC: {alu_carry, alu_result} = {1'b0, alu_a} + 9'd1;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A transfer happens on the next rising edge whenever valid and ready are
    // both high outside reset.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("out_unexpected", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("out_data_sb", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 12'h800;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_acc"},       {24'h0, acc}, 32'h00);
        check({tag, "_carry"},     {31'h0, carry}, 32'h0);
        check({tag, "_pc"},        {24'h0, pc}, 32'h00);
        check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_out_data"},  {24'h0, out_data}, 32'h00);
        check({tag, "_imem_en"},   {31'h0, imem_en}, 32'h0);
        check({tag, "_halted"},    {31'h0, halted}, 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        imem_data = 12'h000;
        clear_rom();
        tick(2);
        rst = 1'b0;
        check_reset_state("reset");
        tick(3);
        check("idle_no_fetch", {31'h0, imem_en}, 32'h0);

        // LDI F0; ADD 20; JC 05; HALT at 05
        rom[0] = 12'h4F0; rom[1] = 12'h020; rom[2] = 12'h605; rom[5] = 12'hF00;
        pulse_start();
        check("fetch_en", {31'h0, imem_en}, 32'h1);
        check("fetch_addr", {24'h0, imem_addr}, 32'h00);
        tick(3);
        check("ldi_acc", {24'h0, acc}, 32'hF0);
        check("ldi_pc", {24'h0, pc}, 32'h01);
        tick(3);
        check("add_acc", {24'h0, acc}, 32'h10);
        check("add_carry", {31'h0, carry}, 32'h1);
        check("add_pc", {24'h0, pc}, 32'h02);
        tick(3);
        check("jc_taken_pc", {24'h0, pc}, 32'h05);
        tick(3);
        check("halt_flag", {31'h0, halted}, 32'h1);
        check("halt_pc", {24'h0, pc}, 32'h05);
        tick(10);
        check("halt_hold_pc", {24'h0, pc}, 32'h05);
        check("halt_hold_flag", {31'h0, halted}, 32'h1);
        check("halt_no_fetch", {31'h0, imem_en}, 32'h0);

        // Restart from HALT: SUB/INC/AND carry behaviour
        clear_rom();
        rom[0] = 12'h405; rom[1] = 12'h105; rom[2] = 12'h405; rom[3] = 12'h106;
        rom[4] = 12'h4FF; rom[5] = 12'h300; rom[6] = 12'h2F0; rom[7] = 12'hF00;
        pulse_start();
        check("restart_halted", {31'h0, halted}, 32'h0);
        check("restart_pc", {24'h0, pc}, 32'h00);
        check("restart_acc", {24'h0, acc}, 32'h00);
        check("restart_carry", {31'h0, carry}, 32'h0);
        check("restart_fetch", {31'h0, imem_en}, 32'h1);
        tick(6);
        check("sub_eq_acc", {24'h0, acc}, 32'h00);
        check("sub_eq_carry", {31'h0, carry}, 32'h1);
        tick(6);
        check("sub_borrow_acc", {24'h0, acc}, 32'hFF);
        check("sub_borrow_carry", {31'h0, carry}, 32'h0);
        tick(6);
        check("inc_wrap_acc", {24'h0, acc}, 32'h00);
        check("inc_wrap_carry", {31'h0, carry}, 32'h1);
        tick(3);
        check("and_acc", {24'h0, acc}, 32'h00);
        check("and_carry", {31'h0, carry}, 32'h0);
        check("and_pc", {24'h0, pc}, 32'h07);
        tick(3);
        check("halt2_flag", {31'h0, halted}, 32'h1);

        // OUT with back-pressure, then JMP FF and wrap through a NOP
        clear_rom();
        rom[0] = 12'h45A; rom[1] = 12'h700; rom[2] = 12'h5FF; rom[255] = 12'h800;
        sb_q.push_back(8'h5A);
        pulse_start();
        tick(3);
        check("out_ldi_acc", {24'h0, acc}, 32'h5A);
        tick(3);
        for (int i = 0; i < 4; i++) begin
            check("out_stall_valid", {31'h0, out_valid}, 32'h1);
            check("out_stall_data", {24'h0, out_data}, 32'h5A);
            check("out_stall_pc", {24'h0, pc}, 32'h01);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_done_valid", {31'h0, out_valid}, 32'h0);
        check("out_done_pc", {24'h0, pc}, 32'h02);
        tick(3);
        check("jmp_pc", {24'h0, pc}, 32'hFF);
        tick(3);
        check("nop_wrap_pc", {24'h0, pc}, 32'h00);

        // Reset in the middle of EXEC of ADD
        do_reset();
        clear_rom();
        rom[0] = 12'h433; rom[1] = 12'h001; rom[2] = 12'hF00;
        pulse_start();
        tick(3);
        check("rst_exec_ldi", {24'h0, acc}, 32'h33);
        tick(2);
        rst = 1'b1;
        tick();
        check_reset_state("rst_exec");
        rst = 1'b0;
        tick(4);
        check("rst_exec_no_fetch", {31'h0, imem_en}, 32'h0);
        check("rst_exec_pc_hold", {24'h0, pc}, 32'h00);

        // Reset while stalled in OUT_WAIT
        clear_rom();
        rom[0] = 12'h477; rom[1] = 12'h700; rom[2] = 12'hF00;
        pulse_start();
        tick(6);
        check("rst_out_pending", {31'h0, out_valid}, 32'h1);
        rst = 1'b1;
        tick();
        check_reset_state("rst_out");
        rst = 1'b0;
        tick(4);
        check("rst_out_no_fetch", {31'h0, imem_en}, 32'h0);

        // Minimum OUT latency with ready held high
        clear_rom();
        rom[0] = 12'h4C3; rom[1] = 12'h700; rom[2] = 12'hF00;
        sb_q.push_back(8'hC3);
        out_ready = 1'b1;
        pulse_start();
        tick(3);
        tick(3);
        check("fast_out_valid", {31'h0, out_valid}, 32'h1);
        check("fast_out_pc", {24'h0, pc}, 32'h01);
        tick();
        check("fast_out_done", {31'h0, out_valid}, 32'h0);
        check("fast_out_pc2", {24'h0, pc}, 32'h02);
        out_ready = 1'b0;
        tick(3);
        check("fast_out_halt", {31'h0, halted}, 32'h1);

        check("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Multi-cycle instruction sequencer that drives the 8-bit combinational ALU from the controller side of its a/b/opcode/result/carry interface. It fetches 12-bit instructions from a synchronous instruction ROM, decodes them, and drives the ALU operands. It writes the ALU result back into an accumulator and carry flag, and handles jumps, immediate loads and a handshaked output port. It sits in the CPU top level next to the ALU instance.

Parameters:
ADDR_W, 8, instruction address / PC width; PC wraps modulo 2^ADDR_W
RESET_PC, 0, PC value after reset and on restart

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  leaves IDLE/HALT and begins execution at RESET_PC
imem_addr  output  ADDR_W  instruction ROM address
imem_en  output  1  ROM read enable; data is valid one cycle later
imem_data  input  12  instruction: [11:8] op, [7:0] imm
alu_a  output  8  ALU operand a (always acc)
alu_b  output  8  ALU operand b
alu_opcode  output  4  ALU opcode
alu_result  input  8  ALU result, combinational from alu_a/alu_b/alu_opcode
alu_carry  input  1  ALU carry_out (for SUB: 1 = no borrow)
out_data  output  8  output port data
out_valid  output  1  output port valid
out_ready  input  1  output port ready
acc  output  8  accumulator
carry  output  1  carry flag
pc  output  ADDR_W  program counter
halted  output  1  high in HALT state

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, acc=0, carry=0, ir=0, out_valid=0, out_data=0, imem_en=0, halted=0. rst overrides everything, including mid-instruction and mid-OUT stall; any pending out_valid drops on the next edge.
- States: IDLE, FETCH, DECODE, EXEC, OUT_WAIT, HALT.
- IDLE: start=1 -> FETCH.
- FETCH: imem_addr=pc, imem_en=1 -> DECODE.
- DECODE: ir <= imem_data -> EXEC.
- EXEC: acts on ir; the default next state is FETCH with pc <= pc+1, wrapping from all-ones to 0.
- Each non-stalling instruction takes 3 cycles.
- Op encoding (ir[11:8]):
  - 0 ADD, 1 SUB, 2 AND, 3 INC: alu_opcode=op, alu_b=imm (don't-care for INC). acc <= alu_result and carry <= alu_carry at the end of EXEC. AND therefore clears carry.
  - 4 LDI: acc <= imm; carry unchanged.
  - 5 JMP: pc <= imm[ADDR_W-1:0].
  - 6 JC: if carry=1 then pc <= imm, else pc+1.
  - 7 OUT: out_data <= acc, out_valid <= 1, next state OUT_WAIT. pc is not incremented yet.
  - F HALT: next state HALT; pc unchanged.
  - 8..E: NOP, pc+1.
- Outside EXEC, and in EXEC for non-ALU ops: alu_opcode=0, alu_b=0. alu_result is ignored.
- OUT_WAIT: out_valid and out_data are held stable until out_valid&&out_ready is seen on a clock edge. On that edge: out_valid <= 0, pc <= pc+1, next state FETCH.
  - out_ready asserted in the same cycle out_valid first rises counts only from the following edge, because out_valid is registered.
  - Minimum OUT latency is 4 cycles.
- HALT: halted=1. start=1 -> FETCH with pc <= RESET_PC, acc <= 0, carry <= 0.
- start is ignored in FETCH, DECODE, EXEC and OUT_WAIT.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_INC=3, shared with the ALU.
  - Instruction op constants (LDI, JMP, JC, OUT, HALT).
  - State enumeration.
  - Instruction field positions.
- No sub-module inside cpu_ctrl. The ALU is instantiated beside it in cpu_top.

Test Plan:
- Program LDI F0; ADD 20; JC 05, then start -> after ADD, acc=10 and carry=1; after JC, pc=05; each instruction takes 3 cycles.
- LDI 05; SUB 06 -> acc=FF, carry=0. LDI 05; SUB 05 -> acc=00, carry=1. LDI FF; INC -> acc=00, carry=1. AND F0 after carry=1 -> carry=0.
- LDI 5A; OUT with out_ready low for 4 cycles then high -> out_valid=1 and out_data=5A stable throughout; pc unchanged until the handshake edge, then pc+1 and out_valid=0 the next cycle.
- JMP FF, with a NOP at FF -> pc=FF, then wraps to 00 after the NOP.
- Assert rst during EXEC of ADD, and again during OUT_WAIT -> next cycle all outputs are at reset values, state=IDLE, and there is no further fetch until start.
- HALT -> halted=1 and pc holds for 10 cycles; start pulse -> halted=0, pc=RESET_PC, acc=0, and the fetch restarts.
